vdma_wr_arbiter: RTL and testbench
==================================

VDMA_WR_ARBITER -- requirements
Module: vdma_wr_arbiter

Interface
REQ-001 The parameters SHALL be: NUM, default 4, number of requesters; LSIZE, default 9, burst length width; ASIZE, default 29, address width; TIMEOUT, default 4096, watchdog limit in cycles.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; all outputs SHALL be registered.
REQ-003 Port axi_aclk SHALL be an input, 1 bit: the single clock.
REQ-004 Port axi_rst SHALL be an input, 1 bit: asynchronous reset, active-high.
REQ-005 Port req SHALL be an input, NUM bits: per-requester burst request, level.
REQ-006 Port req_len SHALL be an input, NUM*LSIZE bits: packed lengths; requester i occupies [i*LSIZE +: LSIZE].
REQ-007 Port req_addr SHALL be an input, NUM*ASIZE bits: packed addresses; requester i occupies [i*ASIZE +: ASIZE].
REQ-008 Port resp SHALL be an output, NUM bits: one-cycle pulse to the owner when downstream accepts the request.
REQ-009 Port done SHALL be an output, NUM bits: one-cycle pulse to the owner when the burst completes.
REQ-010 Port sel SHALL be an output, $clog2(NUM) bits: current owner index, used for the W-data mux.
REQ-011 Port busy SHALL be an output, 1 bit: high while in ISSUE or WAIT.
REQ-012 Port write_req SHALL be an output, 1 bit; wr_len SHALL be an output, LSIZE bits; wr_addr SHALL be an output, ASIZE bits. Together they form the downstream request to the AXI write state core.
REQ-013 Port wr_resp SHALL be an input, 1 bit; wr_done SHALL be an input, 1 bit. Both are downstream pulses.
REQ-014 Port timeout_err SHALL be an output, 1 bit: one-cycle watchdog expiry pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-016 In IDLE, when req is non-zero, the block SHALL grant the first set bit searching upward from ptr+1 modulo NUM; it SHALL latch sel, wr_len and wr_addr, and go to ISSUE.
REQ-017 write_req SHALL be 1 in exactly the ISSUE state; the first assertion SHALL occur 1 cycle after req is sampled in IDLE.
REQ-018 In ISSUE, on wr_resp the block SHALL pulse resp[sel] and go to WAIT; if wr_done is also high in that cycle, it SHALL also pulse done[sel] and go directly to IDLE.
REQ-019 In WAIT, on wr_done the block SHALL pulse done[sel], set ptr to sel, and go to IDLE.
REQ-020 wr_len and wr_addr SHALL stay frozen from grant until return to IDLE; changes on req_len/req_addr meanwhile SHALL be ignored.
REQ-021 Requesters SHALL hold req until resp; a req dropped before grant SHALL simply not be granted.
REQ-022 wr_resp in IDLE or WAIT, and wr_done in IDLE, SHALL be ignored.
REQ-023 The block SHALL spend at least 1 IDLE cycle between consecutive grants.
REQ-024 req_len SHALL pass through unmodified, with AXI encoding (0 = 1 beat).
REQ-025 resp and done SHALL be one-hot or zero.

Reset
REQ-026 On axi_rst the block SHALL force: state=IDLE, ptr=NUM-1 (so requester 0 wins first), sel=0, wr_len=0, wr_addr=0, write_req=0, resp=0, done=0, busy=0, timeout_err=0, watchdog=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst without a done pulse.

Configuration
REQ-028 With macro VDMA_ARB_TIMEOUT_EN defined, a watchdog SHALL clear on grant, count each cycle in ISSUE/WAIT, and on reaching TIMEOUT-1 pulse timeout_err, suppress done, set ptr=sel, and go to IDLE.
REQ-029 With VDMA_ARB_TIMEOUT_EN undefined, the block SHALL contain no counter, tie timeout_err to 0, and wait indefinitely.

Structure
REQ-030 Package vdma_arb_pkg SHALL hold the FSM state enum (IDLE/ISSUE/WAIT) and the default-parameter constants.
REQ-031 The rotate-and-priority-encode function SHALL be one sub-module, rr_pick (inputs req, ptr; output grant index and valid).

Verification
REQ-032 Single request: after reset, req=4'b0001 with len=15 and addr=0x100 -> write_req=1 next cycle with wr_len=15 and wr_addr=0x100; wr_resp -> resp=0001; wr_done -> done=0001; busy low after.
REQ-033 Round-robin fairness: req=1111 held and each burst completed -> grant order 0,1,2,3,0; sel matches the order.
REQ-034 Simultaneous completion: wr_resp and wr_done in the same ISSUE cycle -> resp and done pulse together, next state IDLE, next grant 2 cycles later.
REQ-035 Frozen request: req_addr[1] changes during WAIT -> wr_addr unchanged; spurious wr_resp in WAIT produces no resp pulse.
REQ-036 Watchdog: with VDMA_ARB_TIMEOUT_EN and TIMEOUT=16, wr_done withheld -> timeout_err pulses 16 cycles after grant, no done, next requester granted; without the macro the block stays in WAIT.
REQ-037 Reset mid-burst: axi_rst asserted in WAIT -> all outputs 0 asynchronously; after release, requester 0 has priority.

Source files
------------

// File: rtl/vdma_wr_arbiter_pkg.sv
// vdma_arb_pkg: shared state encoding and default parameters for the
// VDMA write-channel arbiter.
package vdma_arb_pkg;

  localparam int NUM_DEF     = 4;
  localparam int LSIZE_DEF   = 9;
  localparam int ASIZE_DEF   = 29;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vdma_wr_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder. Searches req upward starting at
// ptr+1 (mod NUM) and returns the first set index. Requires NUM >= 2.
module rr_pick #(
  parameter int NUM = 4
) (
  input  logic [NUM-1:0]         req,
  input  logic [$clog2(NUM)-1:0] ptr,
  output logic [$clog2(NUM)-1:0] grant,
  output logic                   valid
);

  localparam int SW = $clog2(NUM);

  logic [SW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = NUM; k >= 1; k--) begin
      idx = SW'((int'(ptr) + k) % NUM);
      if (req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/vdma_wr_arbiter.sv
// vdma_wr_arbiter: round-robin arbiter in front of the AXI write state core.
// Grants one requester at a time, freezes its length/address, forwards the
// downstream accept/complete pulses to the owner, and rotates priority.
// Optional watchdog: define VDMA_ARB_TIMEOUT_EN to abort bursts that never
// complete within TIMEOUT cycles of the grant.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; arbitrate on req, latch winner's len/addr
//   ISSUE | write_req high, waiting for downstream accept (wr_resp)
//   WAIT  | request accepted, waiting for burst completion (wr_done)
module vdma_wr_arbiter
  import vdma_arb_pkg::*;
#(
  parameter int NUM     = NUM_DEF,
  parameter int LSIZE   = LSIZE_DEF,
  parameter int ASIZE   = ASIZE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   axi_aclk,
  input  logic                   axi_rst,
  input  logic [NUM-1:0]         req,
  input  logic [NUM*LSIZE-1:0]   req_len,
  input  logic [NUM*ASIZE-1:0]   req_addr,
  output logic [NUM-1:0]         resp,
  output logic [NUM-1:0]         done,
  output logic [$clog2(NUM)-1:0] sel,
  output logic                   busy,
  output logic                   write_req,
  output logic [LSIZE-1:0]       wr_len,
  output logic [ASIZE-1:0]       wr_addr,
  input  logic                   wr_resp,
  input  logic                   wr_done,
  output logic                   timeout_err
);

  localparam int             SW  = $clog2(NUM);
  localparam logic [NUM-1:0] ONE = NUM'(1);

  arb_state_t    state, state_n;
  logic [SW-1:0] ptr, ptr_n;
  logic [SW-1:0] grant_idx;
  logic          grant_vld;
  logic          grant_take;
  logic          resp_fire;
  logic          done_fire;
  logic          wdog_exp;

  rr_pick #(
    .NUM (NUM)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant_idx),
    .valid (grant_vld)
  );

  // Next-state and pulse decisions; watchdog expiry overrides completion.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_take = 1'b0;
    resp_fire  = 1'b0;
    done_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          grant_take = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (wdog_exp) begin
          ptr_n   = sel;
          state_n = IDLE;
        end else if (wr_resp) begin
          resp_fire = 1'b1;
          if (wr_done) begin
            done_fire = 1'b1;
            ptr_n     = sel;
            state_n   = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (wdog_exp) begin
          ptr_n   = sel;
          state_n = IDLE;
        end else if (wr_done) begin
          done_fire = 1'b1;
          ptr_n     = sel;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and rotation pointer; ptr starts at NUM-1 so requester 0 wins first.
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      state <= IDLE;
      ptr   <= SW'(NUM - 1);
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Registered status and owner pulses, derived from the next state.
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      write_req <= 1'b0;
      busy      <= 1'b0;
      resp      <= '0;
      done      <= '0;
    end else begin
      write_req <= (state_n == ISSUE);
      busy      <= (state_n != IDLE);
      resp      <= resp_fire ? (ONE << sel) : '0;
      done      <= done_fire ? (ONE << sel) : '0;
    end
  end

  // Owner index and request fields are captured once at grant and held.
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      sel     <= '0;
      wr_len  <= '0;
      wr_addr <= '0;
    end else if (grant_take) begin
      sel     <= grant_idx;
      wr_len  <= req_len[grant_idx*LSIZE +: LSIZE];
      wr_addr <= req_addr[grant_idx*ASIZE +: ASIZE];
    end
  end

`ifdef VDMA_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);

  logic [WW-1:0] wdog;

  // Down-counter loaded at grant; terminal count at zero marks expiry.
  assign wdog_exp = (state != IDLE) && (wdog == '0);

  // Watchdog count and its one-cycle error pulse.
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wdog_exp;
      if (grant_take) begin
        wdog <= WW'(TIMEOUT - 1);
      end else if ((state != IDLE) && (wdog != '0)) begin
        wdog <= wdog - 1'b1;
      end
    end
  end
`else
  assign wdog_exp    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vdma_wr_arbiter.sv
// tb_vdma_wr_arbiter: randomized scoreboard bench. The driver plays both the
// requesters and the downstream write core, predicts each grant from the
// round-robin rule, and queues expected grants/pulses; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_vdma_wr_arbiter;

  localparam int NUM   = 4;
  localparam int LSIZE = 9;
  localparam int ASIZE = 29;
`ifdef VDMA_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic                 axi_aclk = 1'b0;
  logic                 axi_rst  = 1'b1;
  logic [NUM-1:0]       req      = '0;
  logic [NUM*LSIZE-1:0] req_len  = '0;
  logic [NUM*ASIZE-1:0] req_addr = '0;
  logic                 wr_resp  = 1'b0;
  logic                 wr_done  = 1'b0;
  logic [NUM-1:0]       resp, done;
  logic [1:0]           sel;
  logic                 busy, write_req, timeout_err;
  logic [LSIZE-1:0]     wr_len;
  logic [ASIZE-1:0]     wr_addr;

  vdma_wr_arbiter #(
    .NUM(NUM), .LSIZE(LSIZE), .ASIZE(ASIZE), .TIMEOUT(TMO)
  ) dut (
    .axi_aclk(axi_aclk), .axi_rst(axi_rst), .req(req), .req_len(req_len),
    .req_addr(req_addr), .resp(resp), .done(done), .sel(sel), .busy(busy),
    .write_req(write_req), .wr_len(wr_len), .wr_addr(wr_addr),
    .wr_resp(wr_resp), .wr_done(wr_done), .timeout_err(timeout_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    int         o;
    logic [8:0] len;
    logic [28:0] addr;
  } gnt_t;

  gnt_t        gq[$];
  logic [3:0]  rq[$];
  logic [3:0]  dq[$];
  bit          tq[$];
  int          hist[$];

  int          vectors = 0;
  int          errors  = 0;
  int          last    = NUM - 1;
  int          cur     = 0;
  bit          allow_add = 1'b0;
  logic [8:0]  len_a[NUM];
  logic [28:0] addr_a[NUM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT-presented grants and pulses against queued expectations.
  gnt_t       g;
  logic       prev_wr = 1'b0;
  logic [8:0] cur_len = '0;
  logic [28:0] cur_addr = '0;
  always @(negedge axi_aclk) begin
    if (axi_rst) begin
      prev_wr = 1'b0;
    end else begin
      if (write_req && !prev_wr) begin
        if (gq.size() == 0) chk("unexpected_grant", 64'd1, 64'd0);
        else begin
          g = gq.pop_front();
          chk("grant_sel", 64'(sel), 64'(g.o));
          chk("grant_len", 64'(wr_len), 64'(g.len));
          chk("grant_addr", 64'(wr_addr), 64'(g.addr));
          cur_len  = g.len;
          cur_addr = g.addr;
          hist.push_back(int'(sel));
        end
      end else if (busy) begin
        chk("frozen_len", 64'(wr_len), 64'(cur_len));
        chk("frozen_addr", 64'(wr_addr), 64'(cur_addr));
      end
      if (resp != '0) begin
        if (rq.size() == 0) chk("unexpected_resp", 64'(resp), 64'd0);
        else chk("resp", 64'(resp), 64'(rq.pop_front()));
      end
      if (done != '0) begin
        if (dq.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
        else chk("done", 64'(done), 64'(dq.pop_front()));
      end
      if (timeout_err) begin
        if (tq.size() == 0) chk("unexpected_timeout", 64'd1, 64'd0);
        else begin
          void'(tq.pop_front());
          chk("timeout_err", 64'(timeout_err), 64'd1);
        end
      end
      prev_wr = write_req;
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] p, input int l);
    for (int k = 1; k <= NUM; k++) if (p[(l + k) % NUM]) return (l + k) % NUM;
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic [8:0] len, input logic [28:0] addr);
    len_a[i]  = len;
    addr_a[i] = addr;
    req_len[i*LSIZE +: LSIZE]  = len;
    req_addr[i*ASIZE +: ASIZE] = addr;
  endtask

  task automatic rand_slot(input int i);
    logic [28:0] a;
    a = 29'($urandom);
    set_slot(i, 9'($urandom_range(0, 511)), a);
  endtask

  task automatic expect_grant();
    int o;
    o = pick(req, last);
    if (o >= 0) begin
      gq.push_back('{o, len_a[o], addr_a[o]});
      cur = o;
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_write_req"}, 64'(write_req), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_resp"}, 64'(resp), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_sel"}, 64'(sel), 64'd0);
    chk({p, "_wr_len"}, 64'(wr_len), 64'd0);
    chk({p, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({p, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic flush_model();
    gq.delete(); rq.delete(); dq.delete(); tq.delete();
    last = NUM - 1;
  endtask

  // Arbiter idle: a few ignored downstream pulses, then raise a request set.
  task automatic start_idle(input logic [3:0] pat);
    repeat ($urandom_range(1, 3)) begin
      wr_resp = 1'($urandom_range(0, 1));
      wr_done = 1'($urandom_range(0, 1));
      tick();
    end
    wr_resp = 1'b0;
    wr_done = 1'b0;
    for (int i = 0; i < NUM; i++) if (pat[i]) begin rand_slot(i); req[i] = 1'b1; end
    expect_grant();
    tick();
    chk("grant_latency", 64'(write_req), 64'd1);
  endtask

  // One burst, entered just after the grant edge.
  // mode: 0 random, 1 resp+done together, 2 withhold done, 3 directed WAIT.
  task automatic burst(input bit hold, input int mode, input bit clr);
    int  d1, d2, k, i;
    bit  simul;
    d1 = $urandom_range(0, 3);
    repeat (d1) tick();
    simul = (mode == 1) || ((mode == 0) && ($urandom_range(0, 3) == 0));
    wr_resp = 1'b1;
    rq.push_back(4'(1 << cur));
    if (simul) begin wr_done = 1'b1; dq.push_back(4'(1 << cur)); end
    tick();
    wr_resp = 1'b0;
    wr_done = 1'b0;
    if (!hold) req[cur] = 1'b0;
    if (clr) req = '0;
    k = d1 + 1;
    if (!simul) begin
      if (mode == 2) begin
`ifdef VDMA_ARB_TIMEOUT_EN
        while (k < TMO - 1) begin tick(); k++; end
        chk("wdog_early", 64'(timeout_err), 64'd0);
        tq.push_back(1'b1);
        tick();
        chk("wdog_pulse", 64'(timeout_err), 64'd1);
        chk("wdog_no_done", 64'(done), 64'd0);
`else
        repeat (40) tick();
        chk("nowdog_busy", 64'(busy), 64'd1);
        chk("nowdog_write_req", 64'(write_req), 64'd0);
        chk("nowdog_timeout", 64'(timeout_err), 64'd0);
        wr_done = 1'b1;
        dq.push_back(4'(1 << cur));
        tick();
        wr_done = 1'b0;
`endif
      end else begin
        if (mode == 3) begin
          wr_resp = 1'b1;
          set_slot(1, len_a[1], ~addr_a[1]);
          tick();
          wr_resp = 1'b0;
        end
        d2 = $urandom_range(0, 5);
        repeat (d2) begin
          case ($urandom_range(0, 3))
            0: wr_resp = 1'b1;
            1: rand_slot($urandom_range(0, 3));
            2: if (!hold) begin
                 i = $urandom_range(0, 3);
                 if (i != cur) begin
                   if (req[i]) req[i] = 1'b0;
                   else if (allow_add) begin rand_slot(i); req[i] = 1'b1; end
                 end
               end
            default: ;
          endcase
          tick();
          wr_resp = 1'b0;
        end
        wr_done = 1'b1;
        dq.push_back(4'(1 << cur));
        tick();
        wr_done = 1'b0;
      end
    end
    last = cur;
    chk("idle_gap_write_req", 64'(write_req), 64'd0);
    if (req != '0) begin
      expect_grant();
      tick();
      chk("regrant_latency", 64'(write_req), 64'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    allow_add = 1'b0;
    while (req != '0 && n < 12) begin burst(1'b0, 0, 1'b0); n++; end
  endtask

  task automatic do_reset();
    axi_rst = 1'b1;
    req = '0;
    #1;
    check_zero("reset");
    flush_model();
    tick();
    axi_rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NUM; i++) set_slot(i, '0, '0);
    repeat (3) @(posedge axi_aclk);
    #1;
    check_zero("por");
    axi_rst = 1'b0;
    tick();

    // Single request from reset
    set_slot(0, 9'd15, 29'h100);
    req[0] = 1'b1;
    expect_grant();
    tick();
    chk("single_write_req", 64'(write_req), 64'd1);
    chk("single_wr_len", 64'(wr_len), 64'd15);
    chk("single_wr_addr", 64'(wr_addr), 64'h100);
    burst(1'b0, 3, 1'b0);
    chk("single_busy_after", 64'(busy), 64'd0);

    // Round-robin with all requesters held
    do_reset();
    hist.delete();
    for (int i = 0; i < NUM; i++) rand_slot(i);
    req = 4'hF;
    expect_grant();
    tick();
    chk("rr_first_latency", 64'(write_req), 64'd1);
    repeat (4) burst(1'b1, 3, 1'b0);
    burst(1'b0, 3, 1'b1);
    chk("rr_count", 64'(hist.size()), 64'd5);
    for (int i = 0; i < 5 && i < hist.size(); i++) chk("rr_order", 64'(hist[i]), 64'(rr_exp[i]));

    // Simultaneous accept/complete with others pending
    start_idle(4'b0110);
    burst(1'b0, 1, 1'b0);
    drain();

    // Randomized traffic
    allow_add = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if (req == '0) start_idle(4'($urandom_range(1, 15)));
      burst(1'b0, 0, 1'b0);
    end
    drain();

    // Completion withheld
    start_idle(4'($urandom_range(0, 15)) | 4'b0101);
    burst(1'b0, 2, 1'b0);
    drain();

    // Reset during WAIT
    start_idle(4'b0100);
    tick();
    wr_resp = 1'b1;
    rq.push_back(4'(1 << cur));
    tick();
    wr_resp = 1'b0;
    req[cur] = 1'b0;
    tick();
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #3;
    axi_rst = 1'b1;
    #1;
    check_zero("midrst");
    flush_model();
    tick();
    axi_rst = 1'b0;
    for (int i = 0; i < NUM; i++) rand_slot(i);
    req = 4'hF;
    expect_grant();
    tick();
    chk("postrst_write_req", 64'(write_req), 64'd1);
    chk("postrst_sel", 64'(sel), 64'd0);
    drain();
    repeat (3) tick();

    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("timeout_queue_empty", 64'(tq.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
